instruction_decode_stage: RTL and testbench
===========================================

Name: instruction_decode_stage

Overview:
- Decode stage directly downstream of instructionGetter. Consumes the 8-bit byte stream it presents every cycle on `instruction`.
- Splits each byte into opcode/register fields and assembles two-byte instructions (opcode + operand byte).
- For jumps and taken branches, drives `parallelFlag`/`parallelAddress` back to instructionGetter to redirect fetch.
- Discards the wrong-path bytes already in flight. Feeds the execute stage through registered decode outputs.

Parameters:
- ADDR_W, 8, width of `parallelAddress`; must be ≤ 8. Target = operand[ADDR_W-1:0].
- FLUSH_CYCLES, 1, wrong-path bytes discarded after the redirect cycle; 0 is legal.

Ports:
- clk  in  1  stage clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instruction  in  8  byte from instructionGetter, new byte every cycle.
- zeroFlag  in  1  zero flag from execute; sampled in the OPERAND cycle of BNZ.
- decValid  out  1  decoded instruction valid this cycle, one-cycle pulse per instruction.
- decOpcode  out  3  opcode.
- decRd  out  2  destination register.
- decRs  out  2  source register.
- decImm  out  8  immediate (LDI only; 0 otherwise).
- parallelFlag  out  1  fetch redirect request to instructionGetter, one-cycle pulse.
- parallelAddress  out  ADDR_W  redirect target.

Behaviour:
- Encoding: [7:5] opcode, [4:3] rd, [2:1] rs, [0] ignored.
- One-byte opcodes:
  - 000 NOP
  - 001 ADD
  - 010 SUB
  - 011 XOR
  - 100 SHL
- Two-byte opcodes (next byte is the operand):
  - 101 LDI
  - 110 JMP
  - 111 BNZ
- All outputs are registered. Reset value of every output is 0; reset state is DECODE and the flush counter is 0.
- Reset is asynchronous and takes effect immediately, mid-instruction or mid-flush. Any captured opcode is dropped.
- DECODE state:
  - One-byte non-NOP op: next cycle decValid=1 with fields. Latency 1; stay in DECODE.
  - NOP: decValid=0, stay in DECODE.
  - Two-byte op: latch opcode/rd/rs, go to OPERAND; decValid=0 next cycle.
- OPERAND state (current byte is the operand):
  - LDI: next cycle decValid=1, decOpcode=5, decRd=latched rd, decImm=byte; go to DECODE.
  - JMP, or BNZ with zeroFlag=0: next cycle parallelFlag=1, parallelAddress=byte[ADDR_W-1:0]; go to REDIRECT.
  - BNZ with zeroFlag=1: no output; go to DECODE, so the next byte is decoded normally.
- REDIRECT state (parallelFlag high this cycle):
  - Byte is discarded; parallelFlag returns to 0 next cycle.
  - Go to FLUSH with counter=FLUSH_CYCLES, or to DECODE if FLUSH_CYCLES=0.
- FLUSH state:
  - Discard byte, decrement counter.
  - When the counter reaches 1 → DECODE, so exactly FLUSH_CYCLES bytes are discarded.
- decValid and parallelFlag are never high in the same cycle. decValid is never high in REDIRECT or FLUSH cycles.
- Fields other than decValid hold their last values when decValid=0; only decValid is meaningful to consumers.
- Back-to-back instructions: a one-byte op every cycle gives decValid high every cycle.
- A two-byte op immediately after another is decoded with no bubble beyond its own operand cycle.
- Operand byte equal to any opcode pattern is treated purely as data.
- Counter width is $clog2(FLUSH_CYCLES+1), minimum 1.

Decomposition:
- Package decode_pkg holds:
  - the opcode enum (NOP..BNZ)
  - the state enum (DECODE, OPERAND, REDIRECT, FLUSH)
  - field bit-position constants
  - the is_two_byte() function
- No sub-module required. The flush counter stays inline.

Test Plan:
- Reset: rst=1 while driving 8'h2C → all outputs 0 immediately. After release, stream of 8'h00 → decValid stays 0.
- ADD: 8'h2C then 8'h00 → one cycle later decValid=1, decOpcode=1, decRd=1, decRs=2. Next cycle decValid=0.
- LDI: 8'hA8 then 8'h5A → no decValid after the first byte. Then decValid=1, decOpcode=5, decRd=1, decImm=8'h5A.
- JMP: 8'hC0, 8'h40, 8'h2C, 8'h2C, 8'h4A with FLUSH_CYCLES=1 → parallelFlag=1 for exactly one cycle with parallelAddress=8'h40. Both 8'h2C bytes are discarded. 8'h4A decodes to SUB, rd=1, rs=1.
- BNZ: 8'hE0, 8'h10, 8'h2C with zeroFlag=1 → no parallelFlag; 8'h2C decoded. Repeat with zeroFlag=0 → parallelFlag=1, parallelAddress=8'h10, then flush as JMP.
- Reset mid-operation: assert rst in the cycle after 8'hA8, and separately during FLUSH → outputs clear asynchronously. After release the first byte is decoded as an opcode, e.g. 8'h2C gives an ADD.

Source files
------------

// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared types and constants for the instruction decode stage.
//   opcode_e  : 3-bit opcode values (NOP..BNZ)
//   state_e   : decode FSM states
//   *_MSB/LSB : bit positions of the fields inside an instruction byte
//   is_two_byte() : true for opcodes that are followed by an operand byte
// ---------------------------------------------------------------------------
package decode_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_XOR = 3'd3,
        OP_SHL = 3'd4,
        OP_LDI = 3'd5,
        OP_JMP = 3'd6,
        OP_BNZ = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_DECODE   = 2'd0,
        ST_OPERAND  = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_e;

    // Byte layout: [7:5] opcode, [4:3] rd, [2:1] rs, [0] unused
    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 1;

    function automatic logic is_two_byte(input opcode_e op);
        return (op == OP_LDI) || (op == OP_JMP) || (op == OP_BNZ);
    endfunction

endpackage

// File: rtl/instruction_decode_stage.sv
// ---------------------------------------------------------------------------
// instruction_decode_stage
// Decodes the byte stream from instructionGetter into registered decode
// outputs for execute, assembles two-byte instructions, and redirects fetch
// on JMP / taken BNZ while discarding the wrong-path bytes in flight.
//
// Ports
//   clk             in   stage clock, rising edge
//   rst             in   asynchronous active-high reset
//   instruction     in   [7:0] byte from instructionGetter, one per cycle
//   zeroFlag        in   zero flag from execute, used in BNZ operand cycle
//   decValid        out  one-cycle pulse per decoded instruction
//   decOpcode       out  [2:0] opcode
//   decRd           out  [1:0] destination register
//   decRs           out  [1:0] source register
//   decImm          out  [7:0] immediate (LDI only, 0 for other ops)
//   parallelFlag    out  one-cycle fetch redirect request
//   parallelAddress out  [ADDR_W-1:0] redirect target
//
// State     | meaning
// ----------+---------------------------------------------------------------
// DECODE    | current byte is an opcode byte
// OPERAND   | current byte is the operand of the latched two-byte opcode
// REDIRECT  | parallelFlag is high; current byte is wrong-path, discarded
// FLUSH     | discarding remaining wrong-path bytes, counter counts down
// ---------------------------------------------------------------------------
module instruction_decode_stage
    import decode_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        instruction,
    input  logic              zeroFlag,
    output logic              decValid,
    output logic [2:0]        decOpcode,
    output logic [1:0]        decRd,
    output logic [1:0]        decRs,
    output logic [7:0]        decImm,
    output logic              parallelFlag,
    output logic [ADDR_W-1:0] parallelAddress
);

    localparam int CNT_W = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

    // Field extraction from the current byte
    opcode_e    w_byte_op;
    logic [1:0] w_byte_rd;
    logic [1:0] w_byte_rs;
    logic       w_unused_bit0;

    assign w_byte_op     = opcode_e'(instruction[OPC_MSB:OPC_LSB]);
    assign w_byte_rd     = instruction[RD_MSB:RD_LSB];
    assign w_byte_rs     = instruction[RS_MSB:RS_LSB];
    assign w_unused_bit0 = instruction[0];

    // FSM and capture registers
    state_e      r_state;
    logic [CNT_W-1:0] r_cnt;
    opcode_e     r_lat_op;
    logic [1:0]  r_lat_rd;
    logic [1:0]  r_lat_rs;

    // Output registers
    logic              r_valid;
    logic [2:0]        r_opc;
    logic [1:0]        r_rd;
    logic [1:0]        r_rs;
    logic [7:0]        r_imm;
    logic              r_pflag;
    logic [ADDR_W-1:0] r_paddr;

    // Next-state values
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    opcode_e           w_lat_op_nxt;
    logic [1:0]        w_lat_rd_nxt;
    logic [1:0]        w_lat_rs_nxt;
    logic              w_valid_nxt;
    logic [2:0]        w_opc_nxt;
    logic [1:0]        w_rd_nxt;
    logic [1:0]        w_rs_nxt;
    logic [7:0]        w_imm_nxt;
    logic              w_pflag_nxt;
    logic [ADDR_W-1:0] w_paddr_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_DECODE;
            r_cnt    <= '0;
            r_lat_op <= OP_NOP;
            r_lat_rd <= '0;
            r_lat_rs <= '0;
            r_valid  <= 1'b0;
            r_opc    <= '0;
            r_rd     <= '0;
            r_rs     <= '0;
            r_imm    <= '0;
            r_pflag  <= 1'b0;
            r_paddr  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_lat_op <= w_lat_op_nxt;
            r_lat_rd <= w_lat_rd_nxt;
            r_lat_rs <= w_lat_rs_nxt;
            r_valid  <= w_valid_nxt;
            r_opc    <= w_opc_nxt;
            r_rd     <= w_rd_nxt;
            r_rs     <= w_rs_nxt;
            r_imm    <= w_imm_nxt;
            r_pflag  <= w_pflag_nxt;
            r_paddr  <= w_paddr_nxt;
        end
    end

    always_comb begin
        // Pulses default low; decode fields and target hold their last value
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_lat_op_nxt = r_lat_op;
        w_lat_rd_nxt = r_lat_rd;
        w_lat_rs_nxt = r_lat_rs;
        w_valid_nxt  = 1'b0;
        w_opc_nxt    = r_opc;
        w_rd_nxt     = r_rd;
        w_rs_nxt     = r_rs;
        w_imm_nxt    = r_imm;
        w_pflag_nxt  = 1'b0;
        w_paddr_nxt  = r_paddr;

        unique case (r_state)
            ST_DECODE: begin
                if (is_two_byte(w_byte_op)) begin
                    w_lat_op_nxt = w_byte_op;
                    w_lat_rd_nxt = w_byte_rd;
                    w_lat_rs_nxt = w_byte_rs;
                    w_state_nxt  = ST_OPERAND;
                end else if (w_byte_op != OP_NOP) begin
                    w_valid_nxt = 1'b1;
                    w_opc_nxt   = w_byte_op;
                    w_rd_nxt    = w_byte_rd;
                    w_rs_nxt    = w_byte_rs;
                    w_imm_nxt   = 8'h00;
                end
            end

            ST_OPERAND: begin
                // The byte here is pure data, whatever its bit pattern
                if (r_lat_op == OP_LDI) begin
                    w_valid_nxt = 1'b1;
                    w_opc_nxt   = OP_LDI;
                    w_rd_nxt    = r_lat_rd;
                    w_rs_nxt    = r_lat_rs;
                    w_imm_nxt   = instruction;
                    w_state_nxt = ST_DECODE;
                end else if ((r_lat_op == OP_BNZ) && zeroFlag) begin
                    w_state_nxt = ST_DECODE;
                end else begin
                    w_pflag_nxt = 1'b1;
                    w_paddr_nxt = instruction[ADDR_W-1:0];
                    w_state_nxt = ST_REDIRECT;
                end
            end

            ST_REDIRECT: begin
                if (FLUSH_CYCLES == 0) begin
                    w_state_nxt = ST_DECODE;
                end else begin
                    w_cnt_nxt   = CNT_W'(FLUSH_CYCLES);
                    w_state_nxt = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                // Counter was loaded with FLUSH_CYCLES; leaving at 1 discards
                // exactly that many bytes. The <= also guards a stray zero.
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = ST_DECODE;
                end
            end

            default: begin
                w_state_nxt = ST_DECODE;
            end
        endcase
    end

    assign decValid        = r_valid;
    assign decOpcode       = r_opc;
    assign decRd           = r_rd;
    assign decRs           = r_rs;
    assign decImm          = r_imm;
    assign parallelFlag    = r_pflag;
    assign parallelAddress = r_paddr;

endmodule

// File: tb/tb_instruction_decode_stage.sv
module tb_instruction_decode_stage;

    logic       clk;
    logic       rst;
    logic [7:0] instruction;
    logic       zeroFlag;
    logic       decValid;
    logic [2:0] decOpcode;
    logic [1:0] decRd;
    logic [1:0] decRs;
    logic [7:0] decImm;
    logic       parallelFlag;
    logic [7:0] parallelAddress;

    int n_tests;
    int n_fail;

    instruction_decode_stage #(
        .ADDR_W       (8),
        .FLUSH_CYCLES (1)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .instruction     (instruction),
        .zeroFlag        (zeroFlag),
        .decValid        (decValid),
        .decOpcode       (decOpcode),
        .decRd           (decRd),
        .decRs           (decRs),
        .decImm          (decImm),
        .parallelFlag    (parallelFlag),
        .parallelAddress (parallelAddress)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte, clock it in, sample the registered result 1ns later
    task automatic feed(input logic [7:0] b, input logic zf);
        instruction = b;
        zeroFlag    = zf;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_v(input string tag, input logic exp);
        chk(tag, {7'b0, decValid}, {7'b0, exp});
    endtask

    task automatic chk_pf(input string tag, input logic exp);
        chk(tag, {7'b0, parallelFlag}, {7'b0, exp});
    endtask

    task automatic chk_fields(input string tag, input logic [2:0] opc,
                              input logic [1:0] rd, input logic [1:0] rs);
        chk({tag, "_opc"}, {5'b0, decOpcode}, {5'b0, opc});
        chk({tag, "_rd"},  {6'b0, decRd},     {6'b0, rd});
        chk({tag, "_rs"},  {6'b0, decRs},     {6'b0, rs});
    endtask

    task automatic chk_all_zero(input string tag);
        chk_v({tag, "_v"}, 1'b0);
        chk_fields(tag, 3'd0, 2'd0, 2'd0);
        chk({tag, "_imm"}, decImm, 8'h00);
        chk_pf({tag, "_pf"}, 1'b0);
        chk({tag, "_pa"}, parallelAddress, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b0;
        instruction = 8'h2C;
        zeroFlag    = 1'b0;

        // Async reset before any clock edge
        #2 rst = 1'b1;
        #1 chk_all_zero("rst_async");
        // Held in reset while an ADD byte is presented
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all_zero("rst_hold");
        rst = 1'b0;

        // NOP stream
        for (int i = 0; i < 3; i++) begin
            feed(8'h00, 1'b0);
            chk_v("nop_v", 1'b0);
        end

        // ADD r1, r2
        feed(8'h2C, 1'b0);
        chk_v("add_v", 1'b1);
        chk_fields("add", 3'd1, 2'd1, 2'd2);
        chk("add_imm", decImm, 8'h00);
        feed(8'h00, 1'b0);
        chk_v("add_v_drop", 1'b0);
        chk_fields("add_hold", 3'd1, 2'd1, 2'd2);

        // LDI r1, 0x5A
        feed(8'hA8, 1'b0);
        chk_v("ldi_op_v", 1'b0);
        feed(8'h5A, 1'b0);
        chk_v("ldi_v", 1'b1);
        chk("ldi_opc", {5'b0, decOpcode}, 8'd5);
        chk("ldi_rd", {6'b0, decRd}, 8'd1);
        chk("ldi_imm", decImm, 8'h5A);
        chk_pf("ldi_pf", 1'b0);

        // JMP 0x40, two wrong-path bytes, then SUB r1, r1
        feed(8'hC0, 1'b0);
        chk_v("jmp_op_v", 1'b0);
        chk_pf("jmp_op_pf", 1'b0);
        feed(8'h40, 1'b0);
        chk_pf("jmp_pf", 1'b1);
        chk("jmp_pa", parallelAddress, 8'h40);
        chk_v("jmp_v", 1'b0);
        feed(8'h2C, 1'b0);
        chk_pf("jmp_redir_pf", 1'b0);
        chk_v("jmp_redir_v", 1'b0);
        feed(8'h2C, 1'b0);
        chk_pf("jmp_flush_pf", 1'b0);
        chk_v("jmp_flush_v", 1'b0);
        feed(8'h4A, 1'b0);
        chk_v("jmp_sub_v", 1'b1);
        chk_fields("jmp_sub", 3'd2, 2'd1, 2'd1);

        // BNZ not taken (zeroFlag=1): following ADD decodes normally
        feed(8'hE0, 1'b0);
        chk_v("bnz_nt_op_v", 1'b0);
        feed(8'h10, 1'b1);
        chk_pf("bnz_nt_pf", 1'b0);
        chk_v("bnz_nt_v", 1'b0);
        feed(8'h2C, 1'b0);
        chk_v("bnz_nt_add_v", 1'b1);
        chk_fields("bnz_nt_add", 3'd1, 2'd1, 2'd2);

        // BNZ taken (zeroFlag=0): redirect, flush, then XOR r1, r3
        feed(8'hE0, 1'b1);
        feed(8'h10, 1'b0);
        chk_pf("bnz_t_pf", 1'b1);
        chk("bnz_t_pa", parallelAddress, 8'h10);
        chk_v("bnz_t_v", 1'b0);
        feed(8'h2C, 1'b0);
        chk_pf("bnz_t_redir_pf", 1'b0);
        chk_v("bnz_t_redir_v", 1'b0);
        feed(8'h2C, 1'b0);
        chk_v("bnz_t_flush_v", 1'b0);
        chk("bnz_t_pa_hold", parallelAddress, 8'h10);
        feed(8'h6E, 1'b0);
        chk_v("bnz_t_xor_v", 1'b1);
        chk_fields("bnz_t_xor", 3'd3, 2'd1, 2'd3);

        // Back-to-back one-byte ops: valid every cycle
        feed(8'h2C, 1'b0);
        chk_v("b2b_add_v", 1'b1);
        chk_fields("b2b_add", 3'd1, 2'd1, 2'd2);
        feed(8'h4A, 1'b0);
        chk_v("b2b_sub_v", 1'b1);
        chk_fields("b2b_sub", 3'd2, 2'd1, 2'd1);
        feed(8'h80, 1'b0);
        chk_v("b2b_shl_v", 1'b1);
        chk_fields("b2b_shl", 3'd4, 2'd0, 2'd0);

        // Back-to-back LDIs, second operand looks like a JMP opcode
        feed(8'hA8, 1'b0);
        chk_v("ldi2a_op_v", 1'b0);
        feed(8'h5A, 1'b0);
        chk_v("ldi2a_v", 1'b1);
        feed(8'hB6, 1'b0);
        chk_v("ldi2b_op_v", 1'b0);
        feed(8'hC0, 1'b0);
        chk_v("ldi2b_v", 1'b1);
        chk("ldi2b_rd", {6'b0, decRd}, 8'd2);
        chk("ldi2b_imm", decImm, 8'hC0);
        chk_pf("ldi2b_pf", 1'b0);
        feed(8'h00, 1'b0);
        chk_v("ldi2b_after_v", 1'b0);
        chk("ldi2b_imm_hold", decImm, 8'hC0);

        // Reset in the cycle after an LDI opcode: operand slot is dropped
        feed(8'hA8, 1'b0);
        rst = 1'b1;
        #1 chk_all_zero("rst_mid_ldi");
        rst = 1'b0;
        feed(8'h2C, 1'b0);
        chk_v("rst_mid_ldi_add_v", 1'b1);
        chk_fields("rst_mid_ldi_add", 3'd1, 2'd1, 2'd2);
        chk("rst_mid_ldi_imm", decImm, 8'h00);

        // Reset during FLUSH: next byte is decoded, not discarded
        feed(8'hC0, 1'b0);
        feed(8'h77, 1'b0);
        chk_pf("rst_fl_pf", 1'b1);
        chk("rst_fl_pa", parallelAddress, 8'h77);
        feed(8'h2C, 1'b0);
        rst = 1'b1;
        #1 chk_all_zero("rst_mid_flush");
        rst = 1'b0;
        feed(8'h2C, 1'b0);
        chk_v("rst_fl_add_v", 1'b1);
        chk_fields("rst_fl_add", 3'd1, 2'd1, 2'd2);

        // Reset while parallelFlag is high clears it at once
        feed(8'hC0, 1'b0);
        feed(8'h33, 1'b0);
        chk_pf("rst_rd_pf_pre", 1'b1);
        rst = 1'b1;
        #1 chk_pf("rst_rd_pf", 1'b0);
        chk("rst_rd_pa", parallelAddress, 8'h00);
        rst = 1'b0;
        feed(8'h4A, 1'b0);
        chk_v("rst_rd_sub_v", 1'b1);
        chk_fields("rst_rd_sub", 3'd2, 2'd1, 2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
